pwm_sample_decoder: RTL and testbench

PWM_SAMPLE_DECODER -- requirements
Module: pwm_sample_decoder

---
 rtl/pwm_sample_decoder.sv | 128 ++++++++++++
 tb/tb_pwm_sample_decoder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_sample_decoder.sv
// rtl/pwm_sample_decoder.sv - PWM audio duty-cycle decoder with one-deep output buffer.
// Optional 3-tap majority glitch filter enabled by defining PWM_DEC_GLITCH_FILTER_EN.
module pwm_sample_decoder #(
    parameter int WINDOW_LOG2 = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       pwm_in,
    output logic [7:0] sample,
    output logic       sample_valid,
    input  logic       sample_ready,
    output logic       overrun
);

    typedef enum logic {EMPTY, FULL} state_t;

    localparam logic [WINDOW_LOG2-1:0] CNT_LAST = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pwm_sync;
    logic                   pwm_s;

    logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
    logic [WINDOW_LOG2:0]   acc_q, acc_d;
    logic [WINDOW_LOG2:0]   acc_sum;
    logic [WINDOW_LOG2:0]   acc_shifted;
    logic [7:0]             result;
    logic                   win_last;

    state_t     state_q, state_d;
    logic [7:0] sample_q, sample_d;
    logic       overrun_q, overrun_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign pwm_sync = sync_q[SYNC_STAGES-1];

`ifdef PWM_DEC_GLITCH_FILTER_EN
    logic [2:0] filt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_q <= '0;
        end else begin
            filt_q <= {filt_q[1:0], pwm_sync};
        end
    end

    assign pwm_s = (filt_q[0] & filt_q[1]) | (filt_q[0] & filt_q[2]) | (filt_q[1] & filt_q[2]);
`else
    assign pwm_s = pwm_sync;
`endif

    // The final window cycle's bit is folded in before shifting, so a full-high window reads 256.
    always_comb begin
        acc_sum     = acc_q + {{WINDOW_LOG2{1'b0}}, pwm_s};
        acc_shifted = acc_sum >> (WINDOW_LOG2 - 8);
        result      = (|acc_shifted[WINDOW_LOG2:8]) ? 8'hFF : acc_shifted[7:0];
        win_last    = ena && (cnt_q == CNT_LAST);
    end

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (!ena) begin
            cnt_d = '0;
            acc_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
            acc_d = win_last ? '0 : acc_sum;
        end
    end

    always_comb begin
        state_d   = state_q;
        sample_d  = sample_q;
        overrun_d = overrun_q;
        case (state_q)
            EMPTY: begin
                if (win_last) begin
                    sample_d = result;
                    state_d  = FULL;
                end
            end
            FULL: begin
                if (win_last) begin
                    if (sample_ready) begin
                        sample_d = result;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else if (sample_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            state_q   <= EMPTY;
            sample_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            state_q   <= state_d;
            sample_q  <= sample_d;
            overrun_q <= overrun_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = (state_q == FULL);
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_pwm_sample_decoder.sv
// tb/tb_pwm_sample_decoder.sv - directed table-driven bench for pwm_sample_decoder.
module tb_pwm_sample_decoder;

    localparam int M_ZERO    = 0;
    localparam int M_ONE     = 1;
    localparam int M_TOGGLE  = 2;
    localparam int M_PULSE16 = 3;
    localparam int M_DUTY25  = 4;

`ifdef PWM_DEC_GLITCH_FILTER_EN
    localparam int EXP_PULSE   = 0;
    localparam int EXP_RST1ST  = 252;
    localparam int EXP_TAIL    = 4;
`else
    localparam int EXP_PULSE   = 16;
    localparam int EXP_RST1ST  = 254;
    localparam int EXP_TAIL    = 2;
`endif

    typedef struct {
        int    mode;
        int    sel;
        int    exp_sample;
        string name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       pwm_in = 1'b0;
    logic       sample_ready;
    logic [7:0] sample8, sample10;
    logic       valid8, valid10;
    logic       ovr8, ovr10;

    int mode = M_ZERO;
    int cyc  = 0;
    int n_tests = 0;
    int n_fail  = 0;

    pwm_sample_decoder #(.WINDOW_LOG2(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pwm_in(pwm_in),
        .sample(sample8), .sample_valid(valid8), .sample_ready(sample_ready), .overrun(ovr8)
    );

    pwm_sample_decoder #(.WINDOW_LOG2(10), .SYNC_STAGES(2)) dut10 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pwm_in(pwm_in),
        .sample(sample10), .sample_valid(valid10), .sample_ready(sample_ready), .overrun(ovr10)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            case (mode)
                M_ONE:     pwm_in = 1'b1;
                M_TOGGLE:  pwm_in = cyc[0];
                M_PULSE16: pwm_in = ((cyc % 16) == 0);
                M_DUTY25:  pwm_in = ((cyc % 4) == 0);
                default:   pwm_in = 1'b0;
            endcase
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int sel_valid(input int sel);
        return (sel == 10) ? int'(valid10) : int'(valid8);
    endfunction

    function automatic int sel_sample(input int sel);
        return (sel == 10) ? int'(sample10) : int'(sample8);
    endfunction

    task automatic wait_valid(input int sel, input int budget);
        int c = 0;
        while (sel_valid(sel) == 1 && c < budget) begin step(1); c++; end
        while (sel_valid(sel) == 0 && c < budget) begin step(1); c++; end
        if (c >= budget) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_valid_timeout: dut%0d gave no sample within %0d cycles", sel, budget);
        end
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{M_ONE,     8,  255,       "w8_const1"};
        vecs[1] = '{M_ZERO,    8,  0,         "w8_const0"};
        vecs[2] = '{M_TOGGLE,  8,  128,       "w8_toggle"};
        vecs[3] = '{M_PULSE16, 8,  EXP_PULSE, "w8_pulse16"};
        vecs[4] = '{M_DUTY25,  10, 64,        "w10_duty25"};
        vecs[5] = '{M_ONE,     10, 255,       "w10_const1"};
        vecs[6] = '{M_TOGGLE,  10, 128,       "w10_toggle"};

        rst_n = 1'b0;
        ena = 1'b0;
        sample_ready = 1'b1;
        step(3);
        check("reset_sample8", int'(sample8), 0);
        check("reset_valid8", int'(valid8), 0);
        check("reset_overrun8", int'(ovr8), 0);
        check("reset_valid10", int'(valid10), 0);
        rst_n = 1'b1;
        ena = 1'b1;

        foreach (vecs[k]) begin
            mode = vecs[k].mode;
            for (int r = 0; r < 3; r++) wait_valid(vecs[k].sel, 3000);
            check({vecs[k].name, "_valid"}, sel_valid(vecs[k].sel), 1);
            check({vecs[k].name, "_sample"}, sel_sample(vecs[k].sel), vecs[k].exp_sample);
        end

        // Overrun: hold ready low across two completions, samples distinguishable by mode
        mode = M_ZERO;
        for (int r = 0; r < 3; r++) wait_valid(8, 3000);
        check("ovr_first_sample", int'(sample8), 0);
        sample_ready = 1'b0;
        mode = M_ONE;
        step(255);
        check("ovr_before_2nd", int'(ovr8), 0);
        step(1);
        check("ovr_after_2nd", int'(ovr8), 1);
        check("ovr_sample_kept", int'(sample8), 0);
        check("ovr_valid_held", int'(valid8), 1);
        sample_ready = 1'b1;
        step(1);
        check("ovr_consumed_valid", int'(valid8), 0);
        check("ovr_sticky", int'(ovr8), 1);
        check("ovr_sample_retained", int'(sample8), 0);

        // Reset mid-window with pwm_in high
        step(40);
        rst_n = 1'b0;
        step(1);
        check("mid_rst_sample", int'(sample8), 0);
        check("mid_rst_valid", int'(valid8), 0);
        check("mid_rst_overrun", int'(ovr8), 0);
        check("mid_rst_overrun10", int'(ovr10), 0);
        rst_n = 1'b1;
        step(255);
        check("post_rst_not_yet", int'(valid8), 0);
        step(1);
        check("post_rst_valid", int'(valid8), 1);
        check("post_rst_sample", int'(sample8), EXP_RST1ST);

        // Ready asserted exactly on the completion cycle while FULL
        sample_ready = 1'b0;
        mode = M_ZERO;
        step(255);
        check("rdy_on_last_hold", int'(sample8), EXP_RST1ST);
        check("rdy_on_last_valid_pre", int'(valid8), 1);
        sample_ready = 1'b1;
        step(1);
        check("rdy_on_last_valid", int'(valid8), 1);
        check("rdy_on_last_sample", int'(sample8), EXP_TAIL);
        check("rdy_on_last_overrun", int'(ovr8), 0);

        // ena low: no completions; fresh window when it returns
        ena = 1'b0;
        step(600);
        check("ena_off_valid", int'(valid8), 0);
        ena = 1'b1;
        step(255);
        check("ena_on_not_yet", int'(valid8), 0);
        step(1);
        check("ena_on_valid", int'(valid8), 1);
        check("ena_on_sample", int'(sample8), 0);
        check("ena_on_overrun", int'(ovr8), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
